// File: rtl/grn_line_writer.sv
// Buffers result lines from the GRN top and issues them as posted memory line
// writes to consecutive addresses; raises done once every line is acknowledged.
module grn_line_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 42
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  req_write,
    input  logic [511:0]          transient,
    output logic                  ack_write,
    input  logic                  finish_in,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [511:0]          wr_data,
    input  logic                  wr_almost_full,
    input  logic                  wr_rsp_valid,
    output logic [31:0]           lines_written,
    output logic                  done
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [511:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           outstanding, outstanding_nxt;
    logic                  push, pop, restart, empty, full, rsp_take;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign restart  = start && (state == IDLE || state == DONE);
    // ack_write high means the producer is still showing the line just taken
    assign push     = (state == RUN) && req_write && !ack_write && !full;
    assign pop      = (state == RUN || state == DRAIN) && !empty && !wr_almost_full;
    assign rsp_take = wr_rsp_valid && (outstanding != '0);

    // Counted at the issue edge so DRAIN never sees a request that is in flight
    // but not yet reflected in the outstanding count.
    always_comb begin
        outstanding_nxt = outstanding + 32'(pop) - 32'(rsp_take);
        if (restart) outstanding_nxt = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish_in && !req_write) state_nxt = DRAIN;
            DRAIN:   if (empty && outstanding_nxt == '0) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            base          <= '0;
            outstanding   <= '0;
            ack_write     <= 1'b0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            lines_written <= '0;
            done          <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            ack_write   <= push;
            wr_valid    <= pop;
            done        <= (state_nxt == DONE);
            count       <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (restart) begin
                base          <= base_addr;
                lines_written <= '0;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PW'(1);
                wr_data       <= mem[rd_ptr];
                wr_addr       <= base + ADDR_WIDTH'(lines_written);
                lines_written <= lines_written + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= transient;
    end
endmodule
